word_adder: RTL and testbench

//   Full-width binary adder for the fetch stage. Its primary use is PC + 4

---
 rtl/word_adder_pkg.sv | 33 +++
 rtl/word_adder_cla_block.sv | 60 ++++++
 rtl/word_adder.sv | 78 +++++++
 tb/tb_word_adder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/word_adder_pkg.sv
// Shared definitions for the word_adder slice.
//   WORD_WIDTH  : operand width, the project-wide word size of 64 bits.
//   SLICE_WIDTH : width of one carry-lookahead slice.
//   FLAG_*      : bit positions inside the 4-bit flag word {N, Z, C, V}.
//   pack_flags  : builds the flag word from individual flags.
package word_adder_pkg;

  localparam int WORD_WIDTH = 64;

  localparam int SLICE_WIDTH = 16;
  localparam int NUM_FLAGS   = 4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic [NUM_FLAGS-1:0] pack_flags(
    input logic n,
    input logic z,
    input logic c,
    input logic v
  );
    logic [NUM_FLAGS-1:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/word_adder_cla_block.sv
// cla_block: 16-bit two-level carry-lookahead adder slice.
//   a, b : 16-bit operands
//   cin  : carry into bit 0
//   sum  : (a + b + cin) mod 2^16
//   cout : carry out of bit 15
// Purely combinational. Four 4-bit groups each produce a group
// generate/propagate pair; the group carries are resolved by lookahead and
// the carries inside each group are derived from that group's carry-in.
module cla_block (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;
  logic [15:0] c;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;

    for (int j = 0; j < 4; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end

    // Group carries: carry into group j+1 is resolved from group G/P only.
    gc[0] = cin;
    for (int j = 0; j < 4; j++) begin
      gc[j+1] = gg[j] | (gp[j] & gc[j]);
    end

    // Bit carries: the first bit of each group takes the group carry,
    // the remaining bits are local to the group.
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0) begin
        c[i] = gc[i/4];
      end else begin
        c[i] = g[i-1] | (p[i-1] & c[i-1]);
      end
    end

    sum  = p ^ c;
    cout = gc[4];
  end

endmodule

// File: rtl/word_adder.sv
// word_adder: full-width binary adder with NZCV flags, mainly used for
// PC + 4 next-address generation in the fetch stage.
//   clk       : system clock, rising edge loads flags_q
//   rst_n     : asynchronous active-low reset, clears flags_q only
//   a_in      : operand A (WIDTH bits)
//   b_in      : operand B (WIDTH bits)
//   add_out   : (a_in + b_in) mod 2^WIDTH, combinational
//   carry_out : unsigned carry out of the MSB, combinational
//   overflow  : signed two's-complement overflow, combinational
//   zero      : add_out == 0, combinational
//   negative  : add_out MSB, combinational
//   flags_q   : registered {negative, zero, carry_out, overflow}
// There is no handshake or enable: outputs follow the inputs continuously,
// and flags_q samples the flags on every rising clock edge.
module word_adder
  import word_adder_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic [WIDTH-1:0]     add_out,
  output logic                 carry_out,
  output logic                 overflow,
  output logic                 zero,
  output logic                 negative,
  output logic [NUM_FLAGS-1:0] flags_q
);

  localparam int NUM_SLICES = WIDTH / SLICE_WIDTH;
  localparam int MSB        = WIDTH - 1;

  if ((WIDTH % SLICE_WIDTH) != 0 || WIDTH < SLICE_WIDTH) begin : g_width_check
    $error("word_adder: WIDTH must be a non-zero multiple of 16");
  end

  // Slices ripple their carry; each slice owns its carry-in/out nets so the
  // chain is a plain sequence of point-to-point connections.
  for (genvar s = 0; s < NUM_SLICES; s++) begin : g_slice
    logic ci;
    logic co;

    if (s == 0) begin : g_first
      assign ci = 1'b0;
    end else begin : g_rest
      assign ci = g_slice[s-1].co;
    end

    cla_block u_cla (
      .a    (a_in[s*SLICE_WIDTH +: SLICE_WIDTH]),
      .b    (b_in[s*SLICE_WIDTH +: SLICE_WIDTH]),
      .cin  (ci),
      .sum  (add_out[s*SLICE_WIDTH +: SLICE_WIDTH]),
      .cout (co)
    );
  end

  assign carry_out = g_slice[NUM_SLICES-1].co;

  // Overflow: operands share a sign and the result sign differs from it.
  assign overflow = (a_in[MSB] == b_in[MSB]) && (add_out[MSB] != a_in[MSB]);
  assign zero     = (add_out == '0);
  assign negative = add_out[MSB];

  logic [NUM_FLAGS-1:0] flags_d;
  assign flags_d = pack_flags(negative, zero, carry_out, overflow);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_word_adder.sv
// Bench for word_adder: directed vector table, hand-written feedback and
// reset sequences, then a randomized sweep against an arithmetic model.
module tb_word_adder;

  localparam int W = 64;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [W-1:0] add_out;
  logic         carry_out;
  logic         overflow;
  logic         zero;
  logic         negative;
  logic [3:0]   flags_q;

  int total = 0;
  int bad   = 0;

  // expected-value queue for the registered flags in the random sweep
  logic [3:0] exp_q[$];

  word_adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_in      (a_in),
    .b_in      (b_in),
    .add_out   (add_out),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative),
    .flags_q   (flags_q)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Unsigned sum at W+1 bits, signed sum at W+2 bits checked against the
  // representable signed range.
  task automatic ref_model(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] s,
    output logic         c,
    output logic         v,
    output logic         z,
    output logic         n
  );
    logic [W:0]          wide;
    logic signed [W+1:0] ssum;
    logic signed [W+1:0] smax;
    logic signed [W+1:0] smin;
    wide = {1'b0, a} + {1'b0, b};
    s    = wide[W-1:0];
    c    = wide[W];
    ssum = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b});
    smax = $signed({3'b000, {(W-1){1'b1}}});
    smin = -smax - 1;
    v    = (ssum > smax) || (ssum < smin);
    z    = (s == '0);
    n    = s[W-1];
  endtask

  // ---------------- checkers ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_comb(input string name, input logic [W-1:0] es,
                            input logic ec, input logic ev, input logic ez, input logic en);
    total++;
    if (add_out !== es || carry_out !== ec || overflow !== ev || zero !== ez || negative !== en) begin
      bad++;
      $display("FAIL %s: got sum=%h c=%b v=%b z=%b n=%b expected sum=%h c=%b v=%b z=%b n=%b",
               name, add_out, carry_out, overflow, zero, negative, es, ec, ev, ez, en);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         c;
    logic         v;
    logic         z;
    logic         n;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [W-1:0] es;
    logic         ec, ev, ez, en;
    logic [W-1:0] ra, rb;
    int           mode;
    int           k;

    tbl[0] = '{64'd4, 64'd0, 64'd4, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{64'd4, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{64'h0000_0000_0000_FFFF, 64'd1, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{64'h0000_FFFF_FFFF_FFFF, 64'd1, 64'h0001_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset held; combinational path must work with no clock edge involved.
    rst_n = 1'b0;
    a_in  = 64'd4;
    b_in  = 64'd0;
    #1;
    check("reset_flags_q", {60'd0, flags_q}, 64'd0);
    check_comb("pc_plus4_no_clock", 64'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_hold_flags_q", {60'd0, flags_q}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: combinational results, then the registered copy after one edge.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      a_in = tbl[i].a;
      b_in = tbl[i].b;
      #1;
      check_comb($sformatf("table_%0d", i), tbl[i].s, tbl[i].c, tbl[i].v, tbl[i].z, tbl[i].n);
      @(posedge clk);
      #1;
      check($sformatf("table_%0d_flags_q", i), {60'd0, flags_q},
            {60'd0, tbl[i].n, tbl[i].z, tbl[i].c, tbl[i].v});
    end

    // Feedback chain: b_in takes the previous add_out each step.
    a_in = 64'd4;
    b_in = 64'd0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("feedback_%0d", i), add_out, 64'(4 * (i + 1)));
      #199;
      b_in = add_out;
    end

    // Register, then reset mid-cycle: flags_q clears at once, sum unaffected.
    @(negedge clk);
    a_in = 64'd4;
    b_in = 64'hFFFF_FFFF_FFFF_FFFC;
    @(posedge clk);
    #1;
    check("case5_flags_q", {60'd0, flags_q}, 64'h6);
    #2;
    rst_n = 1'b0;
    #1;
    check("case5_async_clear", {60'd0, flags_q}, 64'd0);
    check("case5_sum_under_reset", add_out, 64'd0);
    @(posedge clk);
    #1;
    check("case5_clear_held", {60'd0, flags_q}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("case5_clear_until_edge", {60'd0, flags_q}, 64'd0);
    @(posedge clk);
    #1;
    check("case5_reload", {60'd0, flags_q}, 64'h6);

    // Random sweep with biased patterns to stress slice carry boundaries.
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      mode = $urandom_range(0, 3);
      k    = $urandom_range(1, 3);
      ra   = {$urandom, $urandom};
      rb   = {$urandom, $urandom};
      case (mode)
        1: begin
          ra = (64'd1 << (16 * k)) - 64'd1;
          rb = 64'(1 + $urandom_range(0, 2));
        end
        2: rb = (~ra) + 64'($urandom_range(0, 3));
        default: ;
      endcase
      a_in = ra;
      b_in = rb;
      ref_model(ra, rb, es, ec, ev, ez, en);
      exp_q.push_back({en, ez, ec, ev});
      #1;
      check_comb("random_comb", es, ec, ev, ez, en);
      @(posedge clk);
      #1;
      check("random_flags_q", {60'd0, flags_q}, {60'd0, exp_q.pop_front()});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
